fare_table: RTL

- Successor to the single-pair price register. Holds N_TARIFF tariff profiles, each with a start fee and a unit fee.
- Fees are entered from the keypad one digit at a time (decimal accumulate), then committed to a selected field.
- Drives the fee pair of the active tariff to the fare calculator.
- Editing is locked while a trip runs; the active tariff is frozen for the duration of the trip.

---
 rtl/fare_table.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fare_table.sv
`default_nettype none
// ============================================================================
// fare_table : N_TARIFF start/unit fee store with decimal keypad entry. Rev 1.0
// Option macro FARE_ZERO_REJECT_EN: refuse a zero unit fee on ENTER.
// ============================================================================
module fare_table #(
  parameter int FEE_W     = 10,
  parameter int N_TARIFF  = 2,
  parameter int DEF_S_FEE = 15,
  parameter int DEF_G_FEE = 5,
  parameter int MAX_FEE   = 999,
  localparam int TS_W     = (N_TARIFF > 1) ? $clog2(N_TARIFF) : 1,
  localparam int FI_W     = $clog2(2 * N_TARIFF)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flag,
  input  logic [3:0]       key_code,
  input  logic             start,
  input  logic [TS_W-1:0]  tariff_sel,
  output logic [FEE_W-1:0] s_fee,
  output logic [FEE_W-1:0] g_fee,
  output logic [FEE_W-1:0] edit_val,
  output logic [FI_W-1:0]  field_idx,
  output logic             editing,
  output logic             wr_done,
  output logic             err
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_EDIT  = 1'b1;
  localparam logic [3:0] K_FIELD = 4'd10;
  localparam logic [3:0] K_ENTER = 4'd11;
  localparam logic [3:0] K_CLEAR = 4'd12;

  logic [0:0]       state_q, state_d;
  logic [FEE_W-1:0] acc_q, acc_d;
  logic [FI_W-1:0]  field_q, field_d;
  logic [TS_W-1:0]  active_q, active_d;
  logic [FEE_W-1:0] s_tab_q [N_TARIFF];
  logic [FEE_W-1:0] s_tab_d [N_TARIFF];
  logic [FEE_W-1:0] g_tab_q [N_TARIFF];
  logic [FEE_W-1:0] g_tab_d [N_TARIFF];
  logic [FEE_W-1:0] s_fee_q, s_fee_d, g_fee_q, g_fee_d;
  logic             wr_done_q, wr_done_d, err_q, err_d;

  logic             key_ok, is_digit, digit_fits, zero_reject, do_write, trip_abort;
  logic [FEE_W+3:0] acc_ext, acc_next;
  logic [FI_W-1:0]  field_adv;

  assign key_ok     = flag & ~start & (key_code <= K_CLEAR);
  assign is_digit   = (key_code <= 4'd9);
  assign trip_abort = (state_q == S_EDIT) & start;
  assign acc_ext    = {4'b0000, acc_q};
  // x10 as shift-add in a widened word so an overflowing entry is caught, never wrapped
  assign acc_next   = (acc_ext << 3) + (acc_ext << 1) + {{FEE_W{1'b0}}, key_code};
  assign digit_fits = (acc_next <= (FEE_W+4)'(MAX_FEE));
  assign field_adv  = (field_q == FI_W'(2 * N_TARIFF - 1)) ? '0 : field_q + 1'b1;

`ifdef FARE_ZERO_REJECT_EN
  assign zero_reject = (acc_q == '0) & field_q[0];
`else
  assign zero_reject = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (trip_abort) begin
      state_d = S_IDLE;
    end else if (key_ok) begin
      case (state_q)
        S_IDLE:  if (is_digit) state_d = S_EDIT;
        S_EDIT:  if (key_code == K_ENTER || key_code == K_CLEAR) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    editing = (state_q == S_EDIT);
  end

  always_comb begin
    acc_d     = acc_q;
    field_d   = field_q;
    err_d     = err_q;
    wr_done_d = 1'b0;
    do_write  = 1'b0;
    s_tab_d   = s_tab_q;
    g_tab_d   = g_tab_q;
    if (trip_abort) begin
      acc_d = '0;
    end else if (key_ok) begin
      if (key_code == K_FIELD) begin
        field_d = field_adv;
      end else if (state_q == S_IDLE) begin
        if (is_digit) begin
          acc_d = FEE_W'(key_code);
          err_d = 1'b0;
        end
      end else if (is_digit) begin
        if (digit_fits) acc_d = acc_next[FEE_W-1:0];
        else            err_d = 1'b1;
      end else if (key_code == K_ENTER) begin
        acc_d = '0;
        if (zero_reject) begin
          err_d = 1'b1;
        end else begin
          do_write  = 1'b1;
          wr_done_d = 1'b1;
        end
      end else begin
        acc_d = '0;
        err_d = 1'b0;
      end
    end
    for (int i = 0; i < N_TARIFF; i++) begin
      if (do_write && (32'(field_q >> 1) == i)) begin
        if (field_q[0]) g_tab_d[i] = acc_q;
        else            s_tab_d[i] = acc_q;
      end
    end
    // Tariff follows the selector only between trips; out-of-range selects fall back to 0
    if (start)                            active_d = active_q;
    else if (32'(tariff_sel) < N_TARIFF)  active_d = tariff_sel;
    else                                  active_d = '0;
    s_fee_d = s_tab_q[active_d];
    g_fee_d = g_tab_q[active_d];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      field_q   <= '0;
      active_q  <= '0;
      s_fee_q   <= FEE_W'(DEF_S_FEE);
      g_fee_q   <= FEE_W'(DEF_G_FEE);
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < N_TARIFF; i++) begin
        s_tab_q[i] <= FEE_W'(DEF_S_FEE);
        g_tab_q[i] <= FEE_W'(DEF_G_FEE);
      end
    end else begin
      acc_q     <= acc_d;
      field_q   <= field_d;
      active_q  <= active_d;
      s_fee_q   <= s_fee_d;
      g_fee_q   <= g_fee_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
      s_tab_q   <= s_tab_d;
      g_tab_q   <= g_tab_d;
    end
  end

  assign s_fee     = s_fee_q;
  assign g_fee     = g_fee_q;
  assign edit_val  = acc_q;
  assign field_idx = field_q;
  assign wr_done   = wr_done_q;
  assign err       = err_q;

endmodule
`default_nettype wire
